// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: FSM encoding, note indices
// and sample format.
package note_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam int          NOTE_W      = 6;
   localparam logic [5:0]  NOTE_REST   = 6'd0;
   localparam int          NOTE_A4     = 49;
   localparam int          SAMPLE_RATE = 48000;
   localparam int          SAMPLE_W    = 16;

endpackage

// File: rtl/note_step_rom.sv
// Note index to phase-accumulator step lookup, registered (one cycle latency).
// Equal-tempered table around A4 = 440 Hz, generated at elaboration time.
module note_step_rom
   import note_player_pkg::*;
#(
   parameter int PHASE_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NOTE_W-1:0]  note,
   output logic [PHASE_W-1:0] step
);

   logic [PHASE_W-1:0] step_tbl [64];
   logic [PHASE_W-1:0] step_d;
   logic [PHASE_W-1:0] step_q;

   for (genvar i = 0; i < 64; i++) begin : g_tbl
      if (i == 0) begin : g_rest
         assign step_tbl[i] = '0;
      end else begin : g_pitch
         // step = f / Fs * 2^PHASE_W, rounded to nearest
         localparam real FREQ   = 440.0 * 2.0 ** ((i - NOTE_A4) / 12.0);
         localparam real STEP_R = FREQ / SAMPLE_RATE * 2.0 ** PHASE_W;
         localparam int  STEP_I = $rtoi(STEP_R + 0.5);
         assign step_tbl[i] = PHASE_W'(STEP_I);
      end
   end

   always_comb begin
      step_d = step_tbl[note];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= '0;
      end else begin
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/note_player.sv
// One voice: latches a note, counts its duration in beats, and answers codec
// sample requests with a triangle wave two cycles later.
module note_player
   import note_player_pkg::*;
#(
   parameter int PHASE_W   = 20,
   parameter int AMP_SHIFT = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       play_enable,
   input  logic                       load_new_note,
   input  logic [NOTE_W-1:0]          note_to_load,
   input  logic [5:0]                 duration_to_load,
   input  logic                       beat,
   input  logic                       fast_mode,
   input  logic                       generate_next_sample,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       new_sample_ready,
   output logic                       done_with_note,
   output logic                       busy
);

   // Maps phase MSBs onto a full-scale triangle, then scales for mixing headroom.
   function automatic logic signed [SAMPLE_W-1:0] shape_tri(input logic [SAMPLE_W-1:0] u);
      logic signed [17:0] t;
      if (!u[SAMPLE_W-1]) t = $signed({1'b0, u, 1'b0}) - 18'sd32768;
      else                t = 18'sd98303 - $signed({1'b0, u, 1'b0});
      t = t >>> AMP_SHIFT;
      return t[SAMPLE_W-1:0];
   endfunction

   state_e                       state_q, state_d;
   logic [NOTE_W-1:0]            note_q, note_d;
   logic [5:0]                   dur_cnt_q, dur_cnt_d;
   logic [5:0]                   dec_amt;
   logic [PHASE_W-1:0]           phase_q, phase_d;
   logic [PHASE_W-1:0]           step_w;
   logic [SAMPLE_W-1:0]          u_w;
   logic                         sounding;
   logic                         req_q, req_d;
   logic signed [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                         nsr_q, nsr_d;
   logic                         done_q, done_d;
   logic                         busy_q, busy_d;

   note_step_rom #(.PHASE_W(PHASE_W)) u_rom (
      .clk   (clk),
      .reset (reset),
      .note  (note_q),
      .step  (step_w)
   );

   assign u_w      = phase_q[PHASE_W-1 -: SAMPLE_W];
   assign dec_amt  = fast_mode ? 6'd2 : 6'd1;
   assign sounding = play_enable && (state_q != ST_IDLE) && (note_q != NOTE_REST);

   always_comb begin
      state_d   = state_q;
      note_d    = note_q;
      dur_cnt_d = dur_cnt_q;
      unique case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_PLAY: begin
            if (dur_cnt_q == '0) begin
               state_d = ST_FINISH;
            end else if (play_enable && beat) begin
               dur_cnt_d = (dur_cnt_q > dec_amt) ? dur_cnt_q - dec_amt : '0;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // A load always wins, which also swallows an expiry happening this cycle.
      if (load_new_note) begin
         state_d   = ST_PLAY;
         note_d    = note_to_load;
         dur_cnt_d = duration_to_load;
      end
      done_d = (state_d == ST_FINISH);
      busy_d = (state_d != ST_IDLE);

      // Request cycle: advance phase
      phase_d = phase_q;
      if (generate_next_sample && sounding) phase_d = phase_q + step_w;
      req_d = generate_next_sample;

      // Shaping cycle: phase already advanced, result registered for the pulse
      nsr_d    = req_q;
      sample_d = sample_q;
      if (req_q) sample_d = sounding ? shape_tri(u_w) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         note_q    <= NOTE_REST;
         dur_cnt_q <= '0;
         phase_q   <= '0;
         req_q     <= 1'b0;
         sample_q  <= '0;
         nsr_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         note_q    <= note_d;
         dur_cnt_q <= dur_cnt_d;
         phase_q   <= phase_d;
         req_q     <= req_d;
         sample_q  <= sample_d;
         nsr_q     <= nsr_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign sample_out       = sample_q;
   assign new_sample_ready = nsr_q;
   assign done_with_note   = done_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus random traffic, every output
// compared each cycle against a behavioural voice model.
module tb_note_player;

   localparam int PW = 20;

   logic              clk = 1'b0;
   logic              reset, play_enable, load_new_note, beat, fast_mode, generate_next_sample;
   logic [5:0]        note_to_load, duration_to_load;
   logic signed [15:0] s0, s2;
   logic              nsr0, nsr2, done0, done2, busy0, busy2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   note_player #(.PHASE_W(PW), .AMP_SHIFT(0)) dut0 (
      .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
      .note_to_load(note_to_load), .duration_to_load(duration_to_load), .beat(beat),
      .fast_mode(fast_mode), .generate_next_sample(generate_next_sample),
      .sample_out(s0), .new_sample_ready(nsr0), .done_with_note(done0), .busy(busy0));

   note_player #(.PHASE_W(PW), .AMP_SHIFT(2)) dut2 (
      .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
      .note_to_load(note_to_load), .duration_to_load(duration_to_load), .beat(beat),
      .fast_mode(fast_mode), .generate_next_sample(generate_next_sample),
      .sample_out(s2), .new_sample_ready(nsr2), .done_with_note(done2), .busy(busy2));

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural voice model ----------------
   bit     m_on, m_fin, m_req;
   int     m_rem, m_note, m_step;
   longint m_phase;
   int     e_s0, e_s2;
   bit     e_nsr, e_done, e_busy;
   int     done_seen;
   int     sampq[$];

   function automatic int step_of(input int n);
      real r;
      if (n == 0) return 0;
      r = 440.0 * (2.0 ** (real'(n - 49) / 12.0)) / 48000.0 * (2.0 ** PW);
      return $rtoi(r + 0.5);
   endfunction

   function automatic int tri_of(input longint ph, input int sh);
      int u, t;
      u = int'(ph >> (PW - 16));
      t = (u < 32768) ? 2 * u - 32768 : 98303 - 2 * u;
      return t >>> sh;
   endfunction

   task automatic model_step();
      bit sounding;
      int nxt_step;
      if (reset) begin
         m_on = 0; m_fin = 0; m_req = 0; m_rem = 0; m_note = 0; m_step = 0; m_phase = 0;
         e_s0 = 0; e_s2 = 0; e_nsr = 0; e_done = 0; e_busy = 0;
         return;
      end
      sounding = play_enable && (m_on || m_fin) && (m_note != 0);
      nxt_step = step_of(m_note);
      e_nsr = m_req;
      if (m_req) begin
         e_s0 = sounding ? tri_of(m_phase, 0) : 0;
         e_s2 = sounding ? tri_of(m_phase, 2) : 0;
      end
      if (generate_next_sample && sounding)
         m_phase = (m_phase + m_step) % (longint'(1) << PW);
      if (load_new_note) begin
         m_on = 1; m_fin = 0; m_rem = duration_to_load; m_note = note_to_load;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (m_on) begin
         if (m_rem == 0) begin
            m_on = 0; m_fin = 1;
         end else if (play_enable && beat) begin
            m_rem = m_rem - (fast_mode ? 2 : 1);
            if (m_rem < 0) m_rem = 0;
         end
      end
      m_step = nxt_step;
      m_req  = generate_next_sample;
      e_done = m_fin;
      e_busy = m_on || m_fin;
   endtask

   task automatic compare_all();
      check("sample", s0, e_s0);
      check("sample_shift2", s2, e_s2);
      check("nsr", nsr0, e_nsr);
      check("done", done0, e_done);
      check("busy", busy0, e_busy);
      check("done_shift2", done2, e_done);
      if (done0) done_seen++;
      if (nsr0) sampq.push_back(int'(s0));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      load_new_note = 0; beat = 0; generate_next_sample = 0;
   endtask

   task automatic do_reset();
      reset = 1; cycle(); cycle(); reset = 0;
   endtask

   task automatic load(input int n, input int d);
      note_to_load = 6'(n); duration_to_load = 6'(d); load_new_note = 1; cycle();
   endtask

   task automatic beat_gap(input int n, input int gap);
      for (int b = 0; b < n; b++) begin
         beat = 1; cycle();
         for (int g = 0; g < gap; g++) cycle();
      end
   endtask

   initial begin
      reset = 1; play_enable = 1; load_new_note = 0; beat = 0; fast_mode = 0;
      generate_next_sample = 0; note_to_load = '0; duration_to_load = '0;
      @(negedge clk);
      do_reset();
      check("rst_sample", s0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_nsr", nsr0, 0);

      // Note 49, duration 4, normal speed
      done_seen = 0;
      load(49, 4);
      check("busy_after_load", busy0, 1);
      cycle();
      check("step49", dut0.step_w, 9612);
      beat_gap(3, 2);
      beat = 1; cycle();
      check("done_early", done0, 0);
      cycle();
      check("done_pulse", done0, 1);
      cycle();
      check("busy_fall", busy0, 0);
      check("done_once", done_seen, 1);

      // Fast mode: duration 4 and odd duration 3 both take 2 beats
      fast_mode = 1;
      for (int d = 4; d >= 3; d--) begin
         done_seen = 0;
         load(49, d);
         beat_gap(2, 0);
         cycle();
         check("fast_done", done0, 1);
         cycle(); cycle();
         check("fast_done_once", done_seen, 1);
      end
      fast_mode = 0;

      // Three back-to-back requests from phase 0
      do_reset();
      load(49, 63);
      cycle();
      sampq.delete();
      for (int i = 0; i < 3; i++) begin generate_next_sample = 1; cycle(); end
      cycle(); cycle(); cycle();
      check("samp_count", sampq.size(), 3);
      if (sampq.size() == 3) begin
         check("samp0", sampq[0], -31568);
         check("samp1", sampq[1], -30366);
         check("samp2", sampq[2], -29164);
      end

      // Rest note: silent, still counts duration
      done_seen = 0;
      load(0, 2);
      for (int i = 0; i < 4; i++) begin generate_next_sample = 1; beat = (i % 2 == 0); cycle(); end
      cycle(); cycle();
      check("rest_done", done_seen, 1);

      // Pause mid-note: beats ignored, phase held, then resume
      done_seen = 0;
      load(49, 3);
      cycle();
      for (int i = 0; i < 3; i++) begin generate_next_sample = 1; cycle(); end
      play_enable = 0;
      for (int i = 0; i < 6; i++) begin generate_next_sample = 1; beat = 1; cycle(); end
      check("pause_phase", dut0.phase_q, m_phase);
      check("pause_busy", busy0, 1);
      play_enable = 1;
      for (int i = 0; i < 3; i++) begin generate_next_sample = 1; cycle(); end
      beat_gap(3, 1);
      cycle(); cycle();
      check("pause_done", done_seen, 1);

      // Reload on the expiry cycle: no done, fresh 5 beats required
      load(49, 1);
      beat = 1; cycle();
      done_seen = 0;
      load(37, 5);
      check("reload_no_done", done0, 0);
      cycle();
      check("step37", dut0.step_w, 4806);
      beat_gap(4, 1);
      check("reload_no_done_4", done_seen, 0);
      beat_gap(1, 3);
      check("reload_done", done_seen, 1);

      // Reset mid-note
      load(49, 5);
      generate_next_sample = 1; beat = 1; cycle();
      generate_next_sample = 1; cycle();
      reset = 1; cycle(); reset = 0;
      check("midrst_busy", busy0, 0);
      check("midrst_sample", s0, 0);
      check("midrst_nsr", nsr0, 0);
      done_seen = 0;
      beat_gap(8, 0);
      check("midrst_no_done", done_seen, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         reset                = ($urandom_range(0, 299) == 0);
         play_enable          = ($urandom_range(0, 9) != 0);
         load_new_note        = ($urandom_range(0, 24) == 0);
         note_to_load         = 6'($urandom_range(0, 63));
         duration_to_load     = 6'($urandom_range(0, 7));
         beat                 = ($urandom_range(0, 3) == 0);
         fast_mode            = ($urandom_range(0, 2) == 0);
         generate_next_sample = ($urandom_range(0, 2) == 0);
         cycle();
         reset = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
